// File: rtl/stream_demux.sv
// 1-to-N_OUT valid/ready stream demultiplexer with one registered slot per
// output channel; up_sel picks the destination channel for every beat.
module stream_demux #(
   parameter  int N_OUT = 4,
   parameter  int WIDTH = 8,
   localparam int SEL_W = $clog2(N_OUT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   up_valid,
   output logic                   up_ready,
   input  logic [SEL_W-1:0]       up_sel,
   input  logic [WIDTH-1:0]       up_data,
   output logic [N_OUT-1:0]       down_valid,
   input  logic [N_OUT-1:0]       down_ready,
   output logic [N_OUT*WIDTH-1:0] down_data,
   output logic                   sel_err
);

   logic             sel_ok;
   logic [N_OUT-1:0] hit;
   logic [N_OUT-1:0] load;
   logic [N_OUT-1:0] drain;
   logic [WIDTH-1:0] slot_data [N_OUT];

   // NOTE: every always_comb output gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      sel_ok   = 1'b0;
      hit      = '0;
      up_ready = 1'b1;
      // Decode by comparison so an out-of-range select never indexes past
      // the last channel; such a beat is always accepted and discarded.
      for (int i = 0; i < N_OUT; i++) begin
         if (up_sel == SEL_W'(i)) begin
            hit[i]   = 1'b1;
            sel_ok   = 1'b1;
            up_ready = !down_valid[i] || down_ready[i];
         end
      end
   end

   assign load  = (up_valid && up_ready) ? hit : '0;
   assign drain = down_valid & down_ready;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         down_valid <= '0;
         sel_err    <= 1'b0;
      end else begin
         down_valid <= load | (down_valid & ~drain);
         sel_err    <= up_valid && !sel_ok;
      end
   end

   for (genvar g = 0; g < N_OUT; g++) begin : g_slot
      // NOTE: the payload slots are reset as well because down_data must read
      // zero during reset; nothing else would clear a stale beat.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slot_data[g] <= '0;
         end else if (load[g]) begin
            slot_data[g] <= up_data;
         end
      end

      assign down_data[g*WIDTH +: WIDTH] = slot_data[g];
   end

endmodule
